// File: rtl/fir_request_arbiter.sv
// -----------------------------------------------------------------------------
// fir_request_arbiter
//
// Shares one FIR filter datapath between two sample requesters. A request is
// granted round-robin in IDLE, the sample is handed to the FIR core over the
// sample_data/data_ready handshake, and the filtered result (or an error) is
// returned to the requester that issued it.
//
// Optional feature (compile-time macro FIR_ARB_TIMEOUT_EN):
//   Adds a watchdog down-counter that aborts a transaction with an error when
//   the FIR core stays in the wait states for TIMEOUT_CYCLES cycles. Without
//   the macro the FSM waits on modwait indefinitely.
//
// Parameters:
//   TIMEOUT_CYCLES  watchdog budget in cycles (used only with the watchdog)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   req_valid    [1:0]  per-requester request
//   req_sample   [31:0] requester i sample in bits [16i+15:16i]
//   req_ready    [1:0]  one-cycle accept strobe to the granted requester
//   resp_valid   [1:0]  one-cycle result strobe to the owning requester
//   resp_data    [15:0] filtered result, valid with resp_valid
//   resp_err     error flag, valid with resp_valid
//   sample_data  [15:0] sample presented to the FIR core
//   data_ready   FIR sample-valid
//   modwait      FIR busy
//   err          FIR error
//   fir_out      [15:0] FIR result
// -----------------------------------------------------------------------------
module fir_request_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_sample,
  output logic [1:0]  req_ready,
  output logic [1:0]  resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_err,
  output logic [15:0] sample_data,
  output logic        data_ready,
  input  logic        modwait,
  input  logic        err,
  input  logic [15:0] fir_out
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    RESPOND
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [15:0] sample_q, sample_d;
  logic [15:0] result_q, result_d;
  logic        err_q, err_d;
  logic        grant;
  logic        timeout;

`ifdef FIR_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Loaded while ISSUE hands over to WAIT_START, then counts down through both
  // wait states. Reaching zero before the FIR core finishes aborts the job.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE) begin
      cnt_d = CNT_W'(TIMEOUT_CYCLES);
    end else if ((state_q == WAIT_START || state_q == WAIT_DONE) && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign timeout = (cnt_q == '0);
`else
  assign timeout = 1'b0;
`endif

  assign sample_data = sample_q;

  // NOTE: every signal written here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    sample_d   = sample_q;
    result_d   = result_q;
    err_d      = err_q;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    resp_data  = 16'h0000;
    resp_err   = 1'b0;
    data_ready = 1'b0;

    // rr_ptr holds the last owner, so the other requester is preferred; fall
    // back to the last owner when the preferred one is not requesting.
    grant = req_valid[~rr_ptr_q] ? ~rr_ptr_q : rr_ptr_q;

    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          req_ready[grant] = 1'b1;
          sample_d         = grant ? req_sample[31:16] : req_sample[15:0];
          owner_d          = grant;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        data_ready = 1'b1;
        state_d    = WAIT_START;
      end
      WAIT_START: begin
        data_ready = 1'b1;
        if (err || timeout) begin
          err_d    = 1'b1;
          result_d = 16'h0000;
          state_d  = RESPOND;
        end else if (modwait) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // An error reported together with modwait falling still wins.
        if (err || timeout) begin
          err_d    = 1'b1;
          result_d = 16'h0000;
          state_d  = RESPOND;
        end else if (!modwait) begin
          err_d    = 1'b0;
          result_d = fir_out;
          state_d  = RESPOND;
        end
      end
      RESPOND: begin
        resp_valid[owner_q] = 1'b1;
        resp_data           = result_q;
        resp_err            = err_q;
        rr_ptr_d            = owner_q;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset is synchronous, so the state register is only cleared at the next
    // edge; mask the strobes so nothing is accepted or emitted while rst is high.
    if (rst) begin
      req_ready  = 2'b00;
      resp_valid = 2'b00;
      data_ready = 1'b0;
      resp_data  = 16'h0000;
      resp_err   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b1;
      sample_q <= 16'h0000;
      result_q <= 16'h0000;
      err_q    <= 1'b0;
`ifdef FIR_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      sample_q <= sample_d;
      result_q <= result_d;
      err_q    <= err_d;
`ifdef FIR_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule
